// File: rtl/mor1kx_wb_arb_cappuccino.sv
// Register-file writeback arbiter: merges NUM_SRC producers onto one registered RF write port.
// Latency: 1 cycle from accepted/granted beat to rf_we_o. Backpressure: ready = holding buffer empty,
// driven only from registered state; a losing beat parks in its one-entry buffer.
module mor1kx_wb_arb_cappuccino #(
    parameter int OPTION_OPERAND_WIDTH = 32,
    parameter int OPTION_RF_ADDR_WIDTH = 5,
    parameter int NUM_SRC              = 3,
    parameter int ARB_MODE             = 0
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    flush_i,
    input  logic [NUM_SRC-1:0]                      src_valid_i,
    output logic [NUM_SRC-1:0]                      src_ready_o,
    input  logic [NUM_SRC*OPTION_OPERAND_WIDTH-1:0] src_result_i,
    input  logic [NUM_SRC*OPTION_RF_ADDR_WIDTH-1:0] src_addr_i,
    output logic                                    rf_we_o,
    output logic [OPTION_RF_ADDR_WIDTH-1:0]         rf_addr_o,
    output logic [OPTION_OPERAND_WIDTH-1:0]         rf_result_o,
    output logic [NUM_SRC-1:0]                      rf_src_o
);
    localparam int W  = OPTION_OPERAND_WIDTH;
    localparam int A  = OPTION_RF_ADDR_WIDTH;
    localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0] buf_full;
    logic [NUM_SRC-1:0] accept;
    logic [NUM_SRC-1:0] cand;
    logic [NUM_SRC-1:0] gnt_oh;
    logic [W-1:0]       buf_dat  [NUM_SRC];
    logic [A-1:0]       buf_addr [NUM_SRC];
    logic [IW-1:0]      rr_ptr;
    logic [IW-1:0]      rr_next;
    logic [IW-1:0]      gnt_idx;
    logic               gnt_vld;
    logic [IW:0]        cidx;
    logic [W-1:0]       win_dat;
    logic [A-1:0]       win_addr;

    assign src_ready_o = ~buf_full;
    assign accept      = src_valid_i & ~buf_full;
    assign cand        = buf_full | accept;

    // Scan candidates starting at index 0 (fixed) or rr_ptr (round-robin), wrapping at NUM_SRC.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cidx    = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            cidx = (IW+1)'(k);
            if (ARB_MODE == 1)
                cidx = cidx + {1'b0, rr_ptr};
            if (cidx >= (IW+1)'(NUM_SRC))
                cidx = cidx - (IW+1)'(NUM_SRC);
            if (!gnt_vld && cand[cidx[IW-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = cidx[IW-1:0];
            end
        end
    end

    always_comb begin
        gnt_oh = '0;
        if (gnt_vld)
            gnt_oh[gnt_idx] = 1'b1;
    end

    assign win_dat  = buf_full[gnt_idx] ? buf_dat[gnt_idx]  : src_result_i[gnt_idx*W +: W];
    assign win_addr = buf_full[gnt_idx] ? buf_addr[gnt_idx] : src_addr_i[gnt_idx*A +: A];
    assign rr_next  = (gnt_idx == IW'(NUM_SRC-1)) ? '0 : gnt_idx + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_full    <= '0;
            rr_ptr      <= '0;
            rf_we_o     <= 1'b0;
            rf_addr_o   <= '0;
            rf_result_o <= '0;
            rf_src_o    <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                buf_dat[i]  <= '0;
                buf_addr[i] <= '0;
            end
        end else if (flush_i) begin
            // Flush drops everything in flight but keeps the fairness pointer.
            buf_full <= '0;
            rf_we_o  <= 1'b0;
            rf_src_o <= '0;
        end else begin
            rf_we_o  <= gnt_vld;
            rf_src_o <= gnt_oh;
            if (gnt_vld) begin
                rf_addr_o   <= win_addr;
                rf_result_o <= win_dat;
                rr_ptr      <= rr_next;
            end
            for (int i = 0; i < NUM_SRC; i++) begin
                if (gnt_oh[i]) begin
                    buf_full[i] <= 1'b0;
                end else if (accept[i]) begin
                    buf_full[i] <= 1'b1;
                    buf_dat[i]  <= src_result_i[i*W +: W];
                    buf_addr[i] <= src_addr_i[i*A +: A];
                end
            end
        end
    end
endmodule
